// File: rtl/serial_nibble_pkg.sv
// Shared definitions for the serial nibble link: receiver states, line levels
// and frame geometry, also used by the matching transmitter.
package serial_nibble_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned DATA_BITS  = 4;
  localparam logic        STOP_LEVEL = 1'b1;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Total clocks per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input bit parity_en);
    return 1 + DATA_BITS + (parity_en ? 1 : 0) + 1;
  endfunction

endpackage

// File: rtl/nibble_fifo2.sv
// Two-entry FIFO of nibbles; entry 0 is always the head so the output is a
// plain register. Pop is applied before push so a full FIFO can swap in one cycle.
module nibble_fifo2
  import serial_nibble_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic                 full,
  output logic                 empty,
  output logic [DATA_BITS-1:0] head
);

  logic [1:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] e0_q, e0_d;
  logic [DATA_BITS-1:0] e1_q, e1_d;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = e0_q;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop && !empty) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    if (push && (cnt_d != 2'd2)) begin
      if (cnt_d == 2'd0) begin
        e0_d = din;
      end else begin
        e1_d = din;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule

// File: rtl/serial_nibble_receiver.sv
// Framed LSB-first nibble receiver with even parity, framing check, break
// handling and a two-entry valid/ready output buffer.
module serial_nibble_receiver
  import serial_nibble_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialin,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  rx_state_e            state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic push, pop, full, empty, room;

  assign valid      = !empty;
  assign pop        = valid && ready;
  // Room is judged after this cycle's pop.
  assign room       = !full || pop;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (serialin != IDLE_LEVEL) begin
          state_d   = StData;
          idx_d     = 2'd0;
          acc_d     = 1'b0;
          par_bad_d = 1'b0;
        end
      end
      StData: begin
        shift_d[idx_q] = serialin;
        acc_d          = acc_q ^ serialin;
        idx_d          = idx_q + 2'd1;
        if (idx_q == 2'(DATA_BITS - 1)) begin
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        par_bad_d = acc_q ^ serialin;
        state_d   = StStop;
      end
      StStop: begin
        if (serialin == STOP_LEVEL) begin
          state_d = StIdle;
          if (par_bad_q) begin
            perr_d = 1'b1;
          end else if (!room) begin
            ovr_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else begin
          // Parity is deliberately not reported on a framing error.
          ferr_d  = 1'b1;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (serialin == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      shift_q   <= '0;
      acc_q     <= 1'b0;
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  nibble_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .full  (full),
    .empty (empty),
    .head  (data_out)
  );

endmodule

// File: doc/serial_nibble_receiver.md
# serial_nibble_receiver

Framed serial receiver that sits at the far end of the versatile register's serial shift path. It reassembles 4-bit nibbles sent LSB-first, checks the framing and even parity, and presents each good nibble on a parallel port. Accepted nibbles pass through a 2-entry output buffer with a valid/ready handshake, so a consumer can stall for up to two frames without losing data.

## Interface
Parameters:
- PARITY_EN, default 1: 1 means the frame carries an even-parity bit; 0 means no parity bit.

Ports:
- clk  in  1: single clock; every register updates on its rising edge.
- reset  in  1: synchronous, active-high reset.
- serialin  in  1: serial line, one bit per clk, idles high.
- data_out  out  4: head nibble of the buffer; bit 0 is the first data bit received.
- valid  out  1: buffer is non-empty; data_out is meaningful.
- ready  in  1: consumer accepts data_out on a cycle where valid && ready.
- parity_err  out  1: one-cycle pulse when a frame is dropped for bad parity.
- frame_err  out  1: one-cycle pulse when the stop bit is 0.
- overrun  out  1: one-cycle pulse when a good frame is dropped because the buffer is full.

## Operation
- Frame format: start bit (0), then D0..D3, then parity P (only when PARITY_EN=1, with D0^D1^D2^D3^P=0), then stop bit (1).
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: serialin=0 moves to DATA and clears the bit index. serialin=1 stays in IDLE.
- DATA: shift serialin into the shift register at position bit index. After the 4th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: latch the parity result, then go to STOP.
- STOP, serialin=1, parity good, buffer has room: push the nibble, go to IDLE.
- STOP, serialin=1, parity bad: drop the nibble, pulse parity_err, go to IDLE.
- STOP, serialin=1, parity good, buffer full: drop the nibble, pulse overrun, go to IDLE.
- STOP, serialin=0: drop the nibble, pulse frame_err, go to BREAK. Parity is not reported in this case.
- BREAK: stay until serialin=1, then go to IDLE. This keeps a stuck-low line from producing phantom frames.
- Buffer room is judged after any pop in the same cycle. A push and a pop in the same cycle with the buffer full succeeds, and occupancy stays 2.
- Pop occurs when valid && ready. A pop on an empty buffer is ignored.
- The buffer is FIFO-ordered and keeps its occupancy at 0, 1 or 2.

## Timing
- Reset values: FSM in IDLE, buffer empty, valid=0, data_out=4'h0, parity_err=0, frame_err=0, overrun=0.
- Reset in the middle of a frame abandons the partial frame and flushes the buffer. A reset cycle never produces an error pulse.
- Edge numbering: the start bit is sampled at edge k. The data bits are sampled at edges k+1..k+4, the parity bit at k+5 and the stop bit at k+6. With PARITY_EN=0, the stop bit is at k+5.
- Latency: valid and the new data_out (if the buffer was empty) appear right after the stop-bit edge. Error pulses appear in the same cycle as that edge and last exactly one cycle.
- Back-to-back frames: a start bit sampled on the edge right after the stop bit is accepted. Sustained throughput is one nibble per 7 clocks (6 clocks with PARITY_EN=0).
- data_out and valid are registered outputs and hold steady while valid && !ready.

## Structure
- Shared package (serial_nibble_pkg) holds:
  - the state enum;
  - the constants DATA_BITS=4, STOP_LEVEL=1'b1 and IDLE_LEVEL=1'b1, which the matching transmitter also uses;
  - the frame-length function of PARITY_EN.
- One sub-module: nibble_fifo2, a 2-entry, 4-bit FIFO with push, pop, full, empty and head outputs, and synchronous reset.
- The FSM, shift register and parity accumulator live in the top module.

## Test plan
- Good frame, 0xA, PARITY_EN=1: serialin = 0,0,1,0,1,0,1 on consecutive edges, ready=1 → valid=1 with data_out=4'hA for one cycle after the stop edge; no error pulses.
- Parity error: 0xA sent with P=1 → parity_err pulses once; valid stays 0; the next good frame 0x3 (bits 0,1,1,0,0,0,1) is delivered normally.
- Frame error and break: 0x5 sent with stop=0, serialin then held low for 5 cycles, then high for 1 → frame_err pulses once; no frame is started during the low period; a following 0xC frame is received.
- Overrun: ready=0, three back-to-back frames 0x1, 0x2, 0x3 → the buffer holds 0x1 then 0x2; overrun pulses on the third stop edge; raising ready pops 0x1 then 0x2; 0x3 never appears.
- Full with simultaneous pop: buffer holds 0x1, 0x2; ready goes high on the cycle 0x3's stop bit is sampled → 0x3 is accepted, no overrun, and the output sequence is 0x1, 0x2, 0x3.
- Reset mid-frame, and the no-parity build: reset asserted at the third data bit → all outputs return to their reset values and no nibble is produced; then a PARITY_EN=0 build receives 0x9 in a 6-bit frame (0,1,0,0,1,1).
